riscv_run_ctrl: RTL

//   Run controller for the riscv_5stage core: sequences the core reset, runs the core

---
 rtl/riscv_run_ctrl_if.sv | 40 ++++
 rtl/riscv_run_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl_if.sv
// riscv_run_ctrl_if
//   Control/status bundle between the run controller and the core/board side.
//   Inputs to the controller: start, halt, retire, stall.
//   Outputs from the controller: core_rst, running, done, timeout,
//   cycle_cnt, instret_cnt, and stall_cnt when RUN_CTRL_STALL_CNT_EN is defined.
//   modport slave  : the run controller.
//   modport master : the core/board side driving requests and reading status.
interface riscv_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt;
    logic             retire;
    logic             stall;
    logic             core_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    modport slave (
        input  start, halt, retire, stall,
        output core_rst, running, done, timeout, cycle_cnt, instret_cnt
`ifdef RUN_CTRL_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport master (
        output start, halt, retire, stall,
        input  core_rst, running, done, timeout, cycle_cnt, instret_cnt
`ifdef RUN_CTRL_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl
//   Run controller for the riscv_5stage core. Holds the core in reset for
//   RESET_CYCLES cycles, runs it until halt (ecall/ebreak retired) or until the
//   MAX_CYCLES budget expires (0 = no budget), then freezes it in reset.
//   Counts run cycles and retired instructions (saturating, CNT_W bits).
//   Ports:
//     clk   - clock, all logic on posedge
//     rst   - synchronous active-low reset
//     ctrl  - riscv_run_ctrl_if.slave: start/halt/retire/stall in,
//             core_rst/running/done/timeout/cycle_cnt/instret_cnt[/stall_cnt] out
//   Optional feature: define RUN_CTRL_STALL_CNT_EN to add the stall_cnt counter,
//   which counts stalled RUN cycles. Without it the stall input is ignored.
module riscv_run_ctrl #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 15,
    parameter int CNT_W        = 32
) (
    input logic             clk,
    input logic             rst,
    riscv_run_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int               HOLD_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ins_q, ins_d;
    logic              timeout_q, timeout_d;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q;
`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0]  stl_q, stl_d;
`else
    logic              unused_stall;
    assign unused_stall = ctrl.stall;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cyc_d     = cyc_q;
        ins_d     = ins_q;
        timeout_d = timeout_q;
`ifdef RUN_CTRL_STALL_CNT_EN
        stl_d     = stl_q;
`endif
        case (state_q)
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
                if (ctrl.retire && ins_q != CNT_MAX) ins_d = ins_q + 1'b1;
`ifdef RUN_CTRL_STALL_CNT_EN
                if (ctrl.stall && stl_q != CNT_MAX) stl_d = stl_q + 1'b1;
`endif
                // halt takes priority over a budget expiring in the same cycle
                if (ctrl.halt) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (MAX_CYCLES != 0 && cyc_q == BUDGET_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (ctrl.start) begin
                    state_d   = HOLD;
                    hold_d    = '0;
                    cyc_d     = '0;
                    ins_d     = '0;
                    timeout_d = 1'b0;
`ifdef RUN_CTRL_STALL_CNT_EN
                    stl_d     = '0;
`endif
                end
            end
            default: begin
                state_d = HOLD;
                hold_d  = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // the state register after each edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= HOLD;
            hold_q     <= '0;
            cyc_q      <= '0;
            ins_q      <= '0;
            timeout_q  <= 1'b0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef RUN_CTRL_STALL_CNT_EN
            stl_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cyc_q      <= cyc_d;
            ins_q      <= ins_d;
            timeout_q  <= timeout_d;
            core_rst_q <= (state_d != RUN);
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == DONE);
`ifdef RUN_CTRL_STALL_CNT_EN
            stl_q      <= stl_d;
`endif
        end
    end

    assign ctrl.core_rst    = core_rst_q;
    assign ctrl.running     = running_q;
    assign ctrl.done        = done_q;
    assign ctrl.timeout     = timeout_q;
    assign ctrl.cycle_cnt   = cyc_q;
    assign ctrl.instret_cnt = ins_q;
`ifdef RUN_CTRL_STALL_CNT_EN
    assign ctrl.stall_cnt   = stl_q;
`endif

endmodule
